// File: rtl/decode_issue.sv
// Single-entry decode/issue stage with a register scoreboard.
// Holds one instruction until its operands and destination are free.
module decode_issue #(
    parameter int STALL_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [15:0]        in_instr,
    output logic               in_ready,
    output logic               iss_valid,
    input  logic               iss_ready,
    output logic [3:0]         iss_opcode,
    output logic [3:0]         iss_rd,
    output logic [3:0]         RegSource1,
    output logic [3:0]         RegSource2,
    input  logic               wb_valid,
    input  logic [3:0]         wb_dest,
    input  logic [31:0]        wb_data,
    output logic [3:0]         Destination,
    output logic [31:0]        Din,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY,
        READY,
        STALL
    } state_t;

    localparam logic [3:0] NOP_OP = 4'hF;

    state_t      state;
    state_t      state_next;

    logic [3:0]  buf_op;
    logic [3:0]  buf_rd;
    logic [3:0]  buf_rs1;
    logic [3:0]  buf_rs2;
    logic [3:0]  op_next;
    logic [3:0]  rd_next;
    logic [3:0]  rs1_next;
    logic [3:0]  rs2_next;

    logic [15:0] busy;
    logic [15:0] busy_next;
    logic [15:0] busy_byp;
    logic [15:0] wb_mask;
    logic [15:0] set_mask;

    logic        buf_valid;
    logic        valid_next;
    logic        hazard;
    logic        hazard_next;
    logic        issue;
    logic        accept;
    logic        load;

    // A returning writeback frees its register in the same cycle it arrives.
    always_comb begin
        wb_mask  = wb_valid ? (16'd1 << wb_dest) : 16'd0;
        busy_byp = busy & ~wb_mask;
        hazard   = busy_byp[buf_rs1] | busy_byp[buf_rs2] | busy_byp[buf_rd];
    end

    always_comb begin
        Destination = wb_valid ? wb_dest : 4'd0;
        Din         = wb_data;
        iss_opcode  = buf_op;
        iss_rd      = buf_rd;
        RegSource1  = buf_rs1;
        RegSource2  = buf_rs2;
    end

    always_comb begin
        state_next  = state;
        in_ready    = 1'b0;
        buf_valid   = (state != EMPTY);
        iss_valid   = 1'b0;
        issue       = 1'b0;
        accept      = 1'b0;
        load        = 1'b0;
        set_mask    = 16'd0;
        busy_next   = busy;
        op_next     = buf_op;
        rd_next     = buf_rd;
        rs1_next    = buf_rs1;
        rs2_next    = buf_rs2;
        valid_next  = 1'b0;
        hazard_next = 1'b0;

        case (state)
            EMPTY:   in_ready = 1'b1;
            READY:   in_ready = iss_ready;
            default: in_ready = 1'b0;
        endcase

        iss_valid = buf_valid & ~hazard;
        issue     = iss_valid & iss_ready;
        accept    = in_valid & in_ready;
        load      = accept & (in_instr[15:12] != NOP_OP);

        // Set is applied after the clear so an issue to a register wins over its writeback.
        if (issue && (buf_rd != 4'd0)) begin
            set_mask = 16'd1 << buf_rd;
        end
        busy_next = ((busy & ~wb_mask) | set_mask) & 16'hFFFE;

        if (load) begin
            op_next  = in_instr[15:12];
            rd_next  = in_instr[11:8];
            rs1_next = in_instr[7:4];
            rs2_next = in_instr[3:0];
        end

        valid_next  = load | (buf_valid & ~issue);
        hazard_next = busy_next[rs1_next] | busy_next[rs2_next] | busy_next[rd_next];

        if (!valid_next) begin
            state_next = EMPTY;
        end else if (hazard_next) begin
            state_next = STALL;
        end else begin
            state_next = READY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= EMPTY;
            buf_op  <= 4'd0;
            buf_rd  <= 4'd0;
            buf_rs1 <= 4'd0;
            buf_rs2 <= 4'd0;
            busy    <= 16'd0;
        end else begin
            state   <= state_next;
            buf_op  <= op_next;
            buf_rd  <= rd_next;
            buf_rs1 <= rs1_next;
            buf_rs2 <= rs2_next;
            busy    <= busy_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((state == STALL) && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_decode_issue.sv
// Bench for decode_issue: directed scenarios plus randomized traffic
// checked against a scoreboard model; a second instance exercises a 2-bit stall counter.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        iss_ready;
    logic        wb_valid;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;

    logic        in_ready, iss_valid;
    logic [3:0]  iss_opcode, iss_rd, RegSource1, RegSource2, Destination;
    logic [31:0] Din;
    logic [15:0] stall_cnt;

    logic        in_ready_s, iss_valid_s;
    logic [3:0]  iss_opcode_s, iss_rd_s, rs1_s, rs2_s, dest_s;
    logic [31:0] din_s;
    logic [1:0]  stall_cnt_s;

    int nvec = 0;
    int nerr = 0;

    // Reference model state
    bit          m_have;
    logic [3:0]  m_op, m_rd, m_rs1, m_rs2;
    logic [15:0] m_busy;
    int          m_cnt16, m_cnt2;

    always #5 clk = ~clk;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode), .iss_rd(iss_rd), .RegSource1(RegSource1),
        .RegSource2(RegSource2), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .wb_data(wb_data), .Destination(Destination), .Din(Din), .stall_cnt(stall_cnt)
    );

    decode_issue #(.STALL_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_instr(in_instr),
        .in_ready(in_ready_s), .iss_valid(iss_valid_s), .iss_ready(iss_ready),
        .iss_opcode(iss_opcode_s), .iss_rd(iss_rd_s), .RegSource1(rs1_s),
        .RegSource2(rs2_s), .wb_valid(wb_valid), .wb_dest(wb_dest),
        .wb_data(wb_data), .Destination(dest_s), .Din(din_s), .stall_cnt(stall_cnt_s)
    );

    function automatic logic [15:0] m_freed();
        logic [15:0] b;
        b = m_busy;
        if (wb_valid) b[wb_dest] = 1'b0;
        return b;
    endfunction

    function automatic bit m_blocked(input logic [15:0] b);
        return b[m_rs1] | b[m_rs2] | b[m_rd];
    endfunction

    function automatic bit exp_iss_valid();
        return m_have && !m_blocked(m_freed());
    endfunction

    function automatic bit exp_in_ready();
        return !m_have || (!m_blocked(m_busy) && iss_ready);
    endfunction

    task automatic model_reset();
        m_have = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
        m_busy = 16'd0; m_cnt16 = 0; m_cnt2 = 0;
    endtask

    // Advance one clock; the model consumes the inputs present at the edge.
    task automatic cycle();
        bit          stalled, issue, accept;
        logic [15:0] nb;
        stalled = m_have && m_blocked(m_busy);
        issue   = exp_iss_valid() && iss_ready;
        accept  = in_valid && exp_in_ready();
        nb      = m_freed();
        if (issue && m_rd != 4'd0) nb[m_rd] = 1'b1;
        @(posedge clk);
        if (stalled) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
        end
        m_busy = nb;
        if (issue) m_have = 0;
        if (accept && in_instr[15:12] != 4'hF) begin
            m_have = 1;
            {m_op, m_rd, m_rs1, m_rs2} = in_instr;
        end
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_instr = 16'h0; iss_ready = 1; wb_valid = 0; wb_dest = 0; wb_data = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        #3;
        nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("[TB] FAIL reset_iss_valid got %0b want 0", iss_valid); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL reset_in_ready got %0b want 1", in_ready); end
        nvec++; if ({RegSource1, RegSource2, iss_opcode, iss_rd} !== 16'h0) begin nerr++; $display("[TB] FAIL reset_fields got %h want 0000", {RegSource1, RegSource2, iss_opcode, iss_rd}); end
        nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
        nvec++; if (Destination !== 4'd0) begin nerr++; $display("[TB] FAIL reset_destination got %0d want 0", Destination); end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_issue_and_stall();
        in_valid = 1; in_instr = 16'h1123; iss_ready = 1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL accept_empty got %0b want 1", in_ready); end
        cycle();
        in_instr = 16'h2415;
        #1;
        nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("[TB] FAIL first_iss_valid got %0b want 1", iss_valid); end
        nvec++; if ({RegSource1, RegSource2, iss_rd, iss_opcode} !== 16'h2311) begin nerr++; $display("[TB] FAIL first_fields got %h want 2311", {RegSource1, RegSource2, iss_rd, iss_opcode}); end
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL ready_pass_through got %0b want 1", in_ready); end
        cycle();
        in_valid = 0;
        #1;
        nvec++; if ({iss_valid, in_ready} !== 2'b00) begin nerr++; $display("[TB] FAIL stall_entry got valid/ready %b want 00", {iss_valid, in_ready}); end
        for (int i = 1; i <= 3; i++) begin
            cycle();
            nvec++; if (stall_cnt !== 16'(i)) begin nerr++; $display("[TB] FAIL stall_count got %0d want %0d", stall_cnt, i); end
            nvec++; if (stall_cnt_s !== 2'(i)) begin nerr++; $display("[TB] FAIL stall_count_w2 got %0d want %0d", stall_cnt_s, i); end
        end
        wb_valid = 1; wb_dest = 4'd1;
        #1;
        nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("[TB] FAIL wb_bypass_issue got %0b want 1", iss_valid); end
        nvec++; if ({iss_opcode, iss_rd, RegSource1, RegSource2} !== 16'h2415) begin nerr++; $display("[TB] FAIL stalled_fields got %h want 2415", {iss_opcode, iss_rd, RegSource1, RegSource2}); end
        nvec++; if (in_ready !== 1'b0) begin nerr++; $display("[TB] FAIL stall_in_ready got %0b want 0", in_ready); end
        cycle();
        wb_valid = 0;
        #1;
        nvec++; if ({iss_valid, in_ready} !== 2'b01) begin nerr++; $display("[TB] FAIL after_stall_issue got valid/ready %b want 01", {iss_valid, in_ready}); end
        nvec++; if (stall_cnt !== 16'd4) begin nerr++; $display("[TB] FAIL stall_total got %0d want 4", stall_cnt); end
        nvec++; if (stall_cnt_s !== 2'd3) begin nerr++; $display("[TB] FAIL stall_total_w2 got %0d want 3", stall_cnt_s); end
    endtask

    task automatic test_rd_zero_and_writeback();
        in_valid = 1; in_instr = 16'h1023; wb_valid = 1; wb_dest = 4'd4;
        #1;
        nvec++; if (Destination !== 4'd4) begin nerr++; $display("[TB] FAIL wb_dest_out got %0d want 4", Destination); end
        cycle();
        in_valid = 0; wb_valid = 0;
        #1;
        nvec++; if ({iss_valid, iss_rd} !== 5'b1_0000) begin nerr++; $display("[TB] FAIL rd0_present got %b want 10000", {iss_valid, iss_rd}); end
        cycle();
        in_valid = 1; in_instr = 16'h1000;
        cycle();
        in_valid = 0; wb_valid = 1; wb_dest = 4'd5; wb_data = 32'hDEADBEEF;
        #1;
        nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("[TB] FAIL r0_never_busy got %0b want 1", iss_valid); end
        nvec++; if ({Destination, Din} !== {4'd5, 32'hDEADBEEF}) begin nerr++; $display("[TB] FAIL wb_passthrough got %h/%h want 5/deadbeef", Destination, Din); end
        cycle();
        wb_valid = 0; in_valid = 1; in_instr = 16'h1555;
        #1;
        nvec++; if (Destination !== 4'd0) begin nerr++; $display("[TB] FAIL wb_idle_dest got %0d want 0", Destination); end
        cycle();
        in_valid = 0;
        #1;
        nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("[TB] FAIL stray_wb_no_busy got %0b want 1", iss_valid); end
        cycle();
        wb_valid = 1; wb_dest = 4'd5;
        cycle();
        wb_valid = 0;
    endtask

    task automatic test_back_pressure();
        iss_ready = 0; in_valid = 1; in_instr = 16'h1567;
        cycle();
        in_instr = 16'h2899;
        for (int i = 0; i < 3; i++) begin
            #1;
            nvec++; if ({iss_valid, in_ready} !== 2'b10) begin nerr++; $display("[TB] FAIL hold_handshake got valid/ready %b want 10", {iss_valid, in_ready}); end
            nvec++; if ({iss_opcode, iss_rd, RegSource1, RegSource2} !== 16'h1567) begin nerr++; $display("[TB] FAIL hold_fields got %h want 1567", {iss_opcode, iss_rd, RegSource1, RegSource2}); end
            nvec++; if (stall_cnt !== 16'd4) begin nerr++; $display("[TB] FAIL hold_stall_cnt got %0d want 4", stall_cnt); end
            cycle();
        end
        iss_ready = 1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL release_in_ready got %0b want 1", in_ready); end
        cycle();
        in_valid = 0;
        #1;
        nvec++; if ({iss_valid, iss_opcode, iss_rd} !== 9'h1_28) begin nerr++; $display("[TB] FAIL next_after_release got %h want 128", {iss_valid, iss_opcode, iss_rd}); end
        cycle();
        #1;
        nvec++; if (iss_valid !== 1'b0) begin nerr++; $display("[TB] FAIL single_issue got %0b want 0", iss_valid); end
        wb_valid = 1; wb_dest = 4'd5;
        cycle();
        wb_dest = 4'd8;
        cycle();
        wb_valid = 0;
    endtask

    task automatic test_nop_and_saturation();
        in_valid = 1; in_instr = 16'hF000; iss_ready = 1;
        #1;
        nvec++; if (in_ready !== 1'b1) begin nerr++; $display("[TB] FAIL nop_accept got %0b want 1", in_ready); end
        cycle();
        in_instr = 16'h1300;
        #1;
        nvec++; if ({iss_valid, in_ready} !== 2'b01) begin nerr++; $display("[TB] FAIL nop_not_buffered got %b want 01", {iss_valid, in_ready}); end
        cycle();
        in_instr = 16'h2033;
        cycle();
        in_instr = 16'hF000;
        for (int i = 0; i < 6; i++) begin
            #1;
            nvec++; if ({iss_valid, in_ready} !== 2'b00) begin nerr++; $display("[TB] FAIL long_stall got %b want 00", {iss_valid, in_ready}); end
            cycle();
        end
        nvec++; if (stall_cnt !== 16'd10) begin nerr++; $display("[TB] FAIL long_stall_cnt got %0d want 10", stall_cnt); end
        nvec++; if (stall_cnt_s !== 2'd3) begin nerr++; $display("[TB] FAIL saturate_w2 got %0d want 3", stall_cnt_s); end
    endtask

    task automatic test_reset_mid_stall();
        rst_n = 0;
        #1;
        nvec++; if ({iss_valid, in_ready} !== 2'b01) begin nerr++; $display("[TB] FAIL async_reset_handshake got %b want 01", {iss_valid, in_ready}); end
        nvec++; if ({stall_cnt, 14'd0, stall_cnt_s} !== 32'd0) begin nerr++; $display("[TB] FAIL async_reset_counts got %0d/%0d want 0/0", stall_cnt, stall_cnt_s); end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        in_valid = 1; in_instr = 16'h2033;
        cycle();
        in_valid = 0;
        #1;
        nvec++; if (iss_valid !== 1'b1) begin nerr++; $display("[TB] FAIL post_reset_no_stall got %0b want 1", iss_valid); end
        cycle();
        nvec++; if (stall_cnt !== 16'd0) begin nerr++; $display("[TB] FAIL post_reset_stall_cnt got %0d want 0", stall_cnt); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_instr  = {($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 14)),
                         4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
            iss_ready = ($urandom_range(0, 3) != 0);
            wb_valid  = ($urandom_range(0, 2) == 0);
            wb_dest   = 4'($urandom_range(0, 3));
            wb_data   = $urandom;
            #1;
            nvec++; if (iss_valid !== exp_iss_valid()) begin nerr++; $display("[TB] FAIL rnd_iss_valid cycle %0d got %0b want %0b", n, iss_valid, exp_iss_valid()); end
            nvec++; if (in_ready !== exp_in_ready()) begin nerr++; $display("[TB] FAIL rnd_in_ready cycle %0d got %0b want %0b", n, in_ready, exp_in_ready()); end
            nvec++; if ({iss_valid_s, in_ready_s} !== {exp_iss_valid(), exp_in_ready()}) begin nerr++; $display("[TB] FAIL rnd_w2_handshake cycle %0d got %b", n, {iss_valid_s, in_ready_s}); end
            if (m_have) begin
                nvec++; if ({iss_opcode, iss_rd, RegSource1, RegSource2} !== {m_op, m_rd, m_rs1, m_rs2}) begin nerr++; $display("[TB] FAIL rnd_fields cycle %0d got %h want %h", n, {iss_opcode, iss_rd, RegSource1, RegSource2}, {m_op, m_rd, m_rs1, m_rs2}); end
            end
            nvec++; if ({Destination, Din} !== {(wb_valid ? wb_dest : 4'd0), wb_data}) begin nerr++; $display("[TB] FAIL rnd_writeback cycle %0d got %h/%h", n, Destination, Din); end
            nvec++; if (stall_cnt !== 16'(m_cnt16)) begin nerr++; $display("[TB] FAIL rnd_stall_cnt cycle %0d got %0d want %0d", n, stall_cnt, m_cnt16); end
            nvec++; if (stall_cnt_s !== 2'(m_cnt2)) begin nerr++; $display("[TB] FAIL rnd_stall_cnt_w2 cycle %0d got %0d want %0d", n, stall_cnt_s, m_cnt2); end
            cycle();
        end
    endtask

    initial begin
        test_reset();
        test_issue_and_stall();
        test_rd_zero_and_writeback();
        test_back_pressure();
        test_nop_and_saturation();
        test_reset_mid_stall();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Interface
REQ-001 SHALL have parameter STALL_W, default 16, width of the saturating stall counter.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, instruction offered.
REQ-005 SHALL have port in_instr, input, 16, instruction: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2.
REQ-006 SHALL have port in_ready, output, 1, instruction accepted when in_valid & in_ready.
REQ-007 SHALL have port iss_valid, output, 1, decoded instruction presented to execute.
REQ-008 SHALL have port iss_ready, input, 1, execute accepts; issue occurs on iss_valid & iss_ready.
REQ-009 SHALL have port iss_opcode, output, 4, opcode of presented instruction.
REQ-010 SHALL have port iss_rd, output, 4, destination of presented instruction.
REQ-011 SHALL have port RegSource1, output, 4, register file read address 1 (= buffered rs1).
REQ-012 SHALL have port RegSource2, output, 4, register file read address 2 (= buffered rs2).
REQ-013 SHALL have port wb_valid, input, 1, execute result returning.
REQ-014 SHALL have port wb_dest, input, 4, result destination register.
REQ-015 SHALL have port wb_data, input, 32, result value.
REQ-016 SHALL have port Destination, output, 4, register file write address.
REQ-017 SHALL have port Din, output, 32, register file write data.
REQ-018 SHALL have port stall_cnt, output, STALL_W, count of hazard-stall cycles.

Function
REQ-019 SHALL hold one instruction in a buffer; state machine EMPTY (buffer empty), READY (buffered, no hazard), STALL (buffered, hazard).
REQ-020 SHALL assert in_ready in EMPTY, or in READY when iss_ready=1 (accept and issue in same cycle); deasserted in STALL.
REQ-021 SHALL treat opcode 4'hF as NOP: accepted, never buffered, never issued, scoreboard untouched.
REQ-022 SHALL keep a 16-bit scoreboard busy[15:0]; bit 0 permanently 0.
REQ-023 SHALL define hazard = busy'[rs1] | busy'[rs2] | busy'[rd], where busy' is busy with bit wb_dest cleared when wb_valid=1 (same-cycle writeback bypass).
REQ-024 SHALL drive iss_valid = buffer valid & ~hazard (combinational from registered buffer and scoreboard).
REQ-025 SHALL on issue set busy[rd] for rd≠0; on wb_valid clear busy[wb_dest]; if both hit one register in a cycle, set wins.
REQ-026 SHALL drive Destination = wb_valid ? wb_dest : 4'd0, Din = wb_data, combinationally (R0 writes are ignored downstream).
REQ-027 SHALL hold buffer contents and outputs stable while iss_valid & ~iss_ready.
REQ-028 SHALL increment stall_cnt each cycle in STALL, saturating at all-ones.
REQ-029 SHALL ignore wb_valid for a register not busy (no error, busy stays 0).

Reset
REQ-030 SHALL on rst_n=0 immediately force state EMPTY, busy=0, stall_cnt=0, buffer fields 0; thus iss_valid=0, in_ready=1, RegSource1/2=0, iss_opcode=0, iss_rd=0.
REQ-031 SHALL discard any buffered or in-flight instruction on reset mid-operation; first instruction after deassertion issues without stall.

Verification
REQ-032 Bench: reset, in_instr=16'h1123 valid, iss_ready=1 -> next cycle iss_valid=1, RegSource1=2, RegSource2=3, iss_rd=1; following cycle busy[1]=1.
REQ-033 Bench: after 16'h1123 issue, offer 16'h2415 with no writeback -> STALL, in_ready=0, stall_cnt counts 1,2,3; wb_valid=1, wb_dest=1 -> issues that cycle.
REQ-034 Bench: rd=0 instruction 16'h1023 issued -> busy stays 0; wb_valid=1, wb_dest=5, wb_data=32'hDEADBEEF -> Destination=5, Din=32'hDEADBEEF same cycle.
REQ-035 Bench: iss_ready=0 for 3 cycles with READY buffer -> outputs unchanged, in_ready=0, stall_cnt unchanged; iss_ready=1 -> single issue.
REQ-036 Bench: 16'hF000 NOP offered -> accepted, iss_valid stays 0; with STALL_W=2 and long hazard, stall_cnt saturates at 3.
REQ-037 Bench: assert rst_n=0 mid-STALL -> iss_valid=0, busy=0, stall_cnt=0 without a clock edge.
